sad_search_ctrl: RTL and testbench



---
 rtl/sad_search_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// SAD motion-search sequencer: issues every candidate block position in
// raster order, collects one SAD per candidate and keeps the best match.
module sad_search_ctrl #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int BLK_W   = 4,
    parameter int BLK_H   = 4,
    parameter int SAD_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic             CandValid,
    input  logic             CandReady,
    output logic [12:0]      CandPlace,
    input  logic             SadValid,
    input  logic [SAD_W-1:0] SadIn,
    output logic [5:0]       X,
    output logic [5:0]       Y,
    output logic [SAD_W-1:0] BestSad
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [5:0]    XLAST = 6'(FRAME_W - BLK_W);
    localparam logic [5:0]    YLAST = 6'(FRAME_H - BLK_H);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [5:0]       xc, yc, xc_n, yc_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic             busy_n, done_n, err_n, cv_n;
    logic [12:0]      place_n;
    logic [5:0]       x_n, y_n;
    logic [SAD_W-1:0] best_n;

    logic       accept, last, expire, take, xwrap;
    logic [5:0] xadv, yadv;

    function automatic logic [12:0] place_of(input logic [5:0] px,
                                             input logic [5:0] py);
        return 13'(py) * 13'(FRAME_W) + 13'(px);
    endfunction

    assign accept = (state == S_ISSUE) && CandReady;
    assign last   = (xc == XLAST) && (yc == YLAST);
    assign expire = !SadValid && (tmr == TLAST);
    // Strict compare: the earliest candidate keeps a tie.
    assign take   = ((xc == 6'd0) && (yc == 6'd0)) || (SadIn < BestSad);
    assign xwrap  = (xc == XLAST);
    assign xadv   = xwrap ? 6'd0 : xc + 6'd1;
    assign yadv   = xwrap ? yc + 6'd1 : yc;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            xc        <= '0;
            yc        <= '0;
            tmr       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            CandValid <= 1'b0;
            CandPlace <= '0;
            X         <= '0;
            Y         <= '0;
            BestSad   <= '0;
        end else begin
            state     <= state_n;
            xc        <= xc_n;
            yc        <= yc_n;
            tmr       <= tmr_n;
            Busy      <= busy_n;
            Done      <= done_n;
            Err       <= err_n;
            CandValid <= cv_n;
            CandPlace <= place_n;
            X         <= x_n;
            Y         <= y_n;
            BestSad   <= best_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (Start)
                    state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept)
                    state_n = S_WAIT;
            end
            S_WAIT: begin
                if (SadValid)
                    state_n = last ? S_DONE : S_ISSUE;
                else if (expire)
                    state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        xc_n    = xc;
        yc_n    = yc;
        tmr_n   = tmr;
        err_n   = Err;
        place_n = CandPlace;
        x_n     = X;
        y_n     = Y;
        best_n  = BestSad;
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_DONE);
        cv_n    = (state_n == S_ISSUE);
        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    xc_n    = '0;
                    yc_n    = '0;
                    err_n   = 1'b0;
                    place_n = '0;
                    x_n     = '0;
                    y_n     = '0;
                    best_n  = '1;
                end
            end
            S_ISSUE: begin
                if (accept)
                    tmr_n = '0;
            end
            S_WAIT: begin
                tmr_n = tmr + 1'b1;
                if (SadValid) begin
                    if (take) begin
                        x_n    = xc;
                        y_n    = yc;
                        best_n = SadIn;
                    end
                    if (!last) begin
                        xc_n    = xadv;
                        yc_n    = yadv;
                        place_n = place_of(xadv, yadv);
                    end
                end else if (expire) begin
                    err_n = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl on an 8x8 frame with 4x4 blocks
// (25 candidates) and a short watchdog of 4 cycles.
module tb_sad_search_ctrl;

    logic        Clk = 1'b0;
    logic        Rst, Start, CandReady, SadValid;
    logic [7:0]  SadIn;
    logic        Busy, Done, Err, CandValid;
    logic [12:0] CandPlace;
    logic [5:0]  X, Y;
    logic [7:0]  BestSad;

    int checks = 0;
    int errors = 0;

    int sad_mode, stall_idx, stall_n, silent_idx, sv_delay;
    int noise_from, issue_noise, ready_tied, stop_idx;
    int done_cyc, done_cnt, hold9, busy_after, cv1, busy1;

    sad_search_ctrl #(
        .FRAME_W(8), .FRAME_H(8), .BLK_W(4), .BLK_H(4),
        .SAD_W(8), .TIMEOUT(4)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy),
        .Done(Done), .Err(Err), .CandValid(CandValid),
        .CandReady(CandReady), .CandPlace(CandPlace),
        .SadValid(SadValid), .SadIn(SadIn), .X(X), .Y(Y),
        .BestSad(BestSad)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] sad_of(input int i);
        case (sad_mode)
            0:       return (i == 13) ? 8'd5 : 8'(200 - i);
            1:       return 8'd10;
            default: return 8'd255;
        endcase
    endfunction

    task automatic cfg_default();
        sad_mode = 0; stall_idx = -1; stall_n = 0; silent_idx = -1;
        sv_delay = 0; noise_from = -100; issue_noise = 0;
        ready_tied = 1; stop_idx = -1;
    endtask

    task automatic clear_inputs();
        Start = 1'b0; CandReady = 1'b0; SadValid = 1'b0; SadIn = '0;
    endtask

    // Engine model: answers each accepted candidate sv_delay cycles
    // into WAIT; called and returns at a negative clock edge.
    task automatic run();
        int cyc, idx, waitc, stallc;
        done_cyc = -1; done_cnt = 0; hold9 = 0;
        busy_after = -1; cv1 = 0; busy1 = 0;
        idx = 0; waitc = -1; stallc = 0;
        Start = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Start = 1'b0;
        cyc = 1;
        forever begin
            if (cyc == 1) begin cv1 = int'(CandValid); busy1 = int'(Busy); end
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(Busy);
            if (done_cyc >= 0 && cyc == done_cyc + 4) break;
            if (CandValid && CandPlace == 13'd9) hold9++;
            if (cyc > 400) begin
                $display("FAIL run_timeout cycles %0d limit 400", cyc);
                errors++; checks++;
                break;
            end
            CandReady = (ready_tied != 0);
            SadValid  = 1'b0;
            SadIn     = '0;
            Start     = (cyc >= noise_from && cyc < noise_from + 3);
            if (waitc >= 0) begin
                if (idx - 1 == stop_idx) begin
                    clear_inputs();
                    return;
                end
                if (idx - 1 != silent_idx && waitc == sv_delay) begin
                    SadValid = 1'b1; SadIn = sad_of(idx - 1); waitc = -1;
                end else begin
                    waitc++;
                end
            end else if (CandValid) begin
                if (issue_noise != 0) begin SadValid = 1'b1; SadIn = '0; end
                if (idx == stall_idx && stallc < stall_n) begin
                    CandReady = 1'b0; stallc++;
                end else begin
                    CandReady = 1'b1; idx++; waitc = 0;
                end
            end
            @(posedge Clk); @(negedge Clk);
            cyc++;
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        Rst = 1'b1; clear_inputs();
        #12;
        if ({Busy, Done, Err, CandValid} !== 4'b0 || CandPlace !== 13'd0 ||
            X !== 6'd0 || Y !== 6'd0 || BestSad !== 8'd0) begin
            $display("FAIL reset_outputs got b%0d d%0d e%0d v%0d p%0d x%0d y%0d s%0d want all 0",
                     Busy, Done, Err, CandValid, CandPlace, X, Y, BestSad);
            errors++;
        end
        checks++;
        @(negedge Clk); Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_search();
        cfg_default(); run();
        if (cv1 != 1 || busy1 != 1) begin
            $display("FAIL search_cycle1 got valid %0d busy %0d want 1 1", cv1, busy1);
            errors++;
        end
        checks++;
        if (X !== 6'd3 || Y !== 6'd2) begin
            $display("FAIL search_xy got %0d,%0d want 3,2", X, Y); errors++;
        end
        checks++;
        if (BestSad !== 8'd5) begin
            $display("FAIL search_sad got %0d want 5", BestSad); errors++;
        end
        checks++;
        if (done_cyc != 51 || done_cnt != 1) begin
            $display("FAIL search_done got cyc %0d cnt %0d want 51 1", done_cyc, done_cnt);
            errors++;
        end
        checks++;
        if (Err !== 1'b0 || busy_after != 0) begin
            $display("FAIL search_err_busy got err %0d busy %0d want 0 0", Err, busy_after);
            errors++;
        end
        checks++;
    endtask

    task automatic test_ties();
        cfg_default(); sad_mode = 2; run();
        if (X !== 6'd0 || Y !== 6'd0 || BestSad !== 8'd255) begin
            $display("FAIL ties255 got %0d,%0d sad %0d want 0,0 sad 255", X, Y, BestSad);
            errors++;
        end
        checks++;
        cfg_default(); sad_mode = 1; run();
        if (X !== 6'd0 || Y !== 6'd0 || BestSad !== 8'd10) begin
            $display("FAIL ties10 got %0d,%0d sad %0d want 0,0 sad 10", X, Y, BestSad);
            errors++;
        end
        checks++;
    endtask

    task automatic test_backpressure();
        cfg_default(); stall_idx = 6; stall_n = 3; issue_noise = 1; run();
        if (hold9 != 4) begin
            $display("FAIL bp_hold got %0d cycles want 4", hold9); errors++;
        end
        checks++;
        if (done_cyc != 54) begin
            $display("FAIL bp_done got cyc %0d want 54", done_cyc); errors++;
        end
        checks++;
        if (X !== 6'd3 || Y !== 6'd2 || BestSad !== 8'd5) begin
            $display("FAIL bp_result got %0d,%0d sad %0d want 3,2 sad 5", X, Y, BestSad);
            errors++;
        end
        checks++;
    endtask

    task automatic test_watchdog();
        cfg_default(); silent_idx = 2; run();
        if (Err !== 1'b1) begin
            $display("FAIL wd_err got %0d want 1", Err); errors++;
        end
        checks++;
        if (done_cyc != 10 || done_cnt != 1 || busy_after != 0) begin
            $display("FAIL wd_done got cyc %0d cnt %0d busy %0d want 10 1 0",
                     done_cyc, done_cnt, busy_after);
            errors++;
        end
        checks++;
        if (X !== 6'd1 || Y !== 6'd0 || BestSad !== 8'd199) begin
            $display("FAIL wd_best got %0d,%0d sad %0d want 1,0 sad 199", X, Y, BestSad);
            errors++;
        end
        checks++;
    endtask

    task automatic test_threshold();
        cfg_default(); sv_delay = 3; run();
        if (Err !== 1'b0 || done_cyc != 126) begin
            $display("FAIL thresh got err %0d cyc %0d want 0 126", Err, done_cyc);
            errors++;
        end
        checks++;
        if (X !== 6'd3 || Y !== 6'd2 || BestSad !== 8'd5) begin
            $display("FAIL thresh_result got %0d,%0d sad %0d want 3,2 sad 5", X, Y, BestSad);
            errors++;
        end
        checks++;
    endtask

    task automatic test_ignored_inputs();
        cfg_default(); noise_from = 10; issue_noise = 1; run();
        if (done_cyc != 51 || done_cnt != 1) begin
            $display("FAIL ign_done got cyc %0d cnt %0d want 51 1", done_cyc, done_cnt);
            errors++;
        end
        checks++;
        if (X !== 6'd3 || Y !== 6'd2 || BestSad !== 8'd5) begin
            $display("FAIL ign_result got %0d,%0d sad %0d want 3,2 sad 5", X, Y, BestSad);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int dseen;
        cfg_default(); stop_idx = 10; run();
        if (Busy !== 1'b1) begin
            $display("FAIL rmid_busy_before got %0d want 1", Busy); errors++;
        end
        checks++;
        Rst = 1'b1;
        #1;
        if ({Busy, Done, Err, CandValid} !== 4'b0 || CandPlace !== 13'd0 ||
            X !== 6'd0 || Y !== 6'd0 || BestSad !== 8'd0) begin
            $display("FAIL rmid_async got b%0d d%0d e%0d v%0d p%0d x%0d y%0d s%0d want all 0",
                     Busy, Done, Err, CandValid, CandPlace, X, Y, BestSad);
            errors++;
        end
        checks++;
        dseen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (Done || Busy) dseen++;
        end
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (Done || Busy) dseen++;
        end
        if (dseen != 0) begin
            $display("FAIL rmid_idle got %0d active cycles want 0", dseen); errors++;
        end
        checks++;
        cfg_default(); run();
        if (X !== 6'd3 || Y !== 6'd2 || BestSad !== 8'd5 || done_cyc != 51) begin
            $display("FAIL rmid_rerun got %0d,%0d sad %0d cyc %0d want 3,2 sad 5 cyc 51",
                     X, Y, BestSad, done_cyc);
            errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_search();
        test_ties();
        test_backpressure();
        test_watchdog();
        test_threshold();
        test_ignored_inputs();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
